main_ram_arbiter: RTL and testbench

//  Shares the single 16-bit SDRAM controller port (sdram) between three requesters.

---
 rtl/main_ram_arbiter.sv | 231 +++++++++++++++++++++++
 tb/tb_main_ram_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/main_ram_arbiter.sv
// Sequenced, non-preemptive, one-outstanding-op arbiter that shares the SDRAM
// controller port between the SNES core, the ROM loader and the BSRAM dump port.
module main_ram_arbiter #(
    parameter logic [4:0]  BSRAM_BASE     = 5'b10000,
    parameter int unsigned ACCEPT_TIMEOUT = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        snes_rom_rd,
    input  logic        snes_rom_word,
    input  logic [23:0] snes_rom_addr,
    input  logic        snes_bs_rd,
    input  logic        snes_bs_wr,
    input  logic [19:0] snes_bs_addr,
    input  logic [7:0]  snes_bs_d,
    output logic [15:0] snes_q,
    output logic        snes_busy,
    input  logic        ld_wr,
    input  logic [24:0] ld_addr,
    input  logic [15:0] ld_data,
    output logic        ld_ack,
    input  logic        dump_rd,
    input  logic [19:0] dump_addr,
    output logic [7:0]  dump_q,
    output logic        dump_ack,
    output logic [24:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        mem_word,
    output logic [15:0] mem_din,
    input  logic [15:0] mem_dout,
    input  logic        mem_busy
);
    localparam int unsigned CNT_W = $clog2(ACCEPT_TIMEOUT + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WACC  = 3'd2;
    localparam logic [2:0] S_WDONE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [1:0] OWN_SNES = 2'd0;
    localparam logic [1:0] OWN_LD   = 2'd1;
    localparam logic [1:0] OWN_DUMP = 2'd2;

    logic [2:0]       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [1:0]       owner, owner_n;
    logic             op_rd, op_rd_n;
    logic             pend, pend_n, pend_rd, pend_rd_n, pend_word, pend_word_n;
    logic [24:0]      pend_addr, pend_addr_n;
    logic [15:0]      pend_din, pend_din_n;
    logic             prev_rom_rd, prev_bs_act;
    logic [23:0]      prev_rom_addr;
    logic [19:0]      prev_bs_addr;
    logic [7:0]       prev_bs_d;
    logic [24:0]      mem_addr_n;
    logic [15:0]      mem_din_n, snes_q_n;
    logic [7:0]       dump_q_n;
    logic             mem_rd_n, mem_wr_n, mem_word_n, ld_ack_n, dump_ack_n, snes_busy_n;
    logic             finish;

    // SNES request detection against the previous cycle's bus values
    logic        bs_act, rom_ev, bs_ev, ev, ev_rd, ev_word;
    logic [24:0] ev_addr;
    logic [15:0] ev_din;

    assign bs_act  = snes_bs_rd | snes_bs_wr;
    assign rom_ev  = snes_rom_rd && (!prev_rom_rd || (snes_rom_addr != prev_rom_addr));
    assign bs_ev   = bs_act && (!prev_bs_act || (snes_bs_addr != prev_bs_addr)
                     || (snes_bs_wr && (snes_bs_d != prev_bs_d)));
    assign ev      = rom_ev | bs_ev;
    assign ev_rd   = bs_ev ? !snes_bs_wr : 1'b1;
    assign ev_addr = bs_ev ? {BSRAM_BASE, snes_bs_addr} : {1'b0, snes_rom_addr};
    assign ev_din  = bs_ev ? {snes_bs_d, snes_bs_d} : 16'h0000;
    assign ev_word = bs_ev ? 1'b0 : snes_rom_word;

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        owner_n     = owner;
        op_rd_n     = op_rd;
        pend_n      = pend;
        pend_rd_n   = pend_rd;
        pend_addr_n = pend_addr;
        pend_din_n  = pend_din;
        pend_word_n = pend_word;
        mem_addr_n  = mem_addr;
        mem_din_n   = mem_din;
        mem_word_n  = mem_word;
        mem_rd_n    = 1'b0;
        mem_wr_n    = 1'b0;
        snes_q_n    = snes_q;
        dump_q_n    = dump_q;
        ld_ack_n    = 1'b0;
        dump_ack_n  = 1'b0;
        finish      = 1'b0;

        // Newest SNES request always replaces an older unissued one
        if (ev) begin
            pend_n      = 1'b1;
            pend_rd_n   = ev_rd;
            pend_addr_n = ev_addr;
            pend_din_n  = ev_din;
            pend_word_n = ev_word;
        end

        case (state)
            S_IDLE: begin
                if (pend_n) begin
                    state_n    = S_ISSUE;
                    owner_n    = OWN_SNES;
                    op_rd_n    = pend_rd_n;
                    mem_addr_n = pend_addr_n;
                    mem_din_n  = pend_din_n;
                    mem_word_n = pend_word_n;
                    mem_rd_n   = pend_rd_n;
                    mem_wr_n   = !pend_rd_n;
                    pend_n     = 1'b0;
                end else if (ld_wr) begin
                    state_n    = S_ISSUE;
                    owner_n    = OWN_LD;
                    op_rd_n    = 1'b0;
                    mem_addr_n = ld_addr;
                    mem_din_n  = ld_data;
                    mem_word_n = 1'b1;
                    mem_wr_n   = 1'b1;
                end else if (dump_rd) begin
                    state_n    = S_ISSUE;
                    owner_n    = OWN_DUMP;
                    op_rd_n    = 1'b1;
                    mem_addr_n = {BSRAM_BASE, dump_addr};
                    mem_din_n  = 16'h0000;
                    mem_word_n = 1'b0;
                    mem_rd_n   = 1'b1;
                end
            end
            S_ISSUE: begin
                state_n = S_WACC;
                cnt_n   = '0;
            end
            S_WACC: begin
                if (mem_busy) begin
                    state_n = S_WDONE;
                end else if (cnt == CNT_W'(ACCEPT_TIMEOUT - 1)) begin
                    // controller completed without ever showing busy
                    state_n = S_DONE;
                    finish  = 1'b1;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            S_WDONE: begin
                if (!mem_busy) begin
                    state_n = S_DONE;
                    finish  = 1'b1;
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase

        if (finish) begin
            case (owner)
                OWN_SNES: if (op_rd) snes_q_n = mem_dout;
                OWN_LD:   ld_ack_n = 1'b1;
                OWN_DUMP: begin
                    dump_q_n   = mem_dout[7:0];
                    dump_ack_n = 1'b1;
                end
                default: ;
            endcase
        end

        snes_busy_n = pend_n || ((state_n != S_IDLE) && (owner_n == OWN_SNES));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            cnt           <= '0;
            owner         <= OWN_SNES;
            op_rd         <= 1'b0;
            pend          <= 1'b0;
            pend_rd       <= 1'b0;
            pend_addr     <= '0;
            pend_din      <= '0;
            pend_word     <= 1'b0;
            prev_rom_rd   <= 1'b0;
            prev_rom_addr <= '0;
            prev_bs_act   <= 1'b0;
            prev_bs_addr  <= '0;
            prev_bs_d     <= '0;
            mem_addr      <= '0;
            mem_din       <= '0;
            mem_word      <= 1'b0;
            mem_rd        <= 1'b0;
            mem_wr        <= 1'b0;
            snes_q        <= '0;
            snes_busy     <= 1'b0;
            dump_q        <= '0;
            ld_ack        <= 1'b0;
            dump_ack      <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            owner         <= owner_n;
            op_rd         <= op_rd_n;
            pend          <= pend_n;
            pend_rd       <= pend_rd_n;
            pend_addr     <= pend_addr_n;
            pend_din      <= pend_din_n;
            pend_word     <= pend_word_n;
            prev_rom_rd   <= snes_rom_rd;
            prev_rom_addr <= snes_rom_addr;
            prev_bs_act   <= bs_act;
            prev_bs_addr  <= snes_bs_addr;
            prev_bs_d     <= snes_bs_d;
            mem_addr      <= mem_addr_n;
            mem_din       <= mem_din_n;
            mem_word      <= mem_word_n;
            mem_rd        <= mem_rd_n;
            mem_wr        <= mem_wr_n;
            snes_q        <= snes_q_n;
            snes_busy     <= snes_busy_n;
            dump_q        <= dump_q_n;
            ld_ack        <= ld_ack_n;
            dump_ack      <= dump_ack_n;
        end
    end
endmodule

// File: tb/tb_main_ram_arbiter.sv
// Directed bench for main_ram_arbiter with a small SDRAM controller model.
module tb_main_ram_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        snes_rom_rd = 1'b0, snes_rom_word = 1'b0;
    logic [23:0] snes_rom_addr = '0;
    logic        snes_bs_rd = 1'b0, snes_bs_wr = 1'b0;
    logic [19:0] snes_bs_addr = '0;
    logic [7:0]  snes_bs_d = '0;
    logic [15:0] snes_q;
    logic        snes_busy;
    logic        ld_wr = 1'b0;
    logic [24:0] ld_addr = '0;
    logic [15:0] ld_data = '0;
    logic        ld_ack;
    logic        dump_rd = 1'b0;
    logic [19:0] dump_addr = '0;
    logic [7:0]  dump_q;
    logic        dump_ack;
    logic [24:0] mem_addr;
    logic        mem_rd, mem_wr, mem_word;
    logic [15:0] mem_din;
    logic [15:0] model_dout = '0;
    logic        mem_busy = 1'b0;

    main_ram_arbiter dut (
        .clk(clk), .reset(reset),
        .snes_rom_rd(snes_rom_rd), .snes_rom_word(snes_rom_word), .snes_rom_addr(snes_rom_addr),
        .snes_bs_rd(snes_bs_rd), .snes_bs_wr(snes_bs_wr), .snes_bs_addr(snes_bs_addr),
        .snes_bs_d(snes_bs_d), .snes_q(snes_q), .snes_busy(snes_busy),
        .ld_wr(ld_wr), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ack(ld_ack),
        .dump_rd(dump_rd), .dump_addr(dump_addr), .dump_q(dump_q), .dump_ack(dump_ack),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_word(mem_word),
        .mem_din(mem_din), .mem_dout(model_dout), .mem_busy(mem_busy)
    );

    always #5 clk = ~clk;

    // Controller model: busy rises the cycle after a pulse, stays high busy_len cycles
    logic        stall = 1'b0;
    int          busy_len = 2;
    int          busy_left = 0;
    int          op_cnt = 0, overlap = 0, ld_ack_cnt = 0;
    logic [24:0] op_addr [32];
    logic [15:0] op_din  [32];
    logic        op_rd   [32];
    logic        op_word [32];

    always @(posedge clk) begin
        if (mem_rd && mem_wr) overlap++;
        if (ld_ack) ld_ack_cnt++;
        if (mem_rd || mem_wr) begin
            if (op_cnt < 32) begin
                op_addr[op_cnt] = mem_addr;
                op_din[op_cnt]  = mem_din;
                op_rd[op_cnt]   = mem_rd;
                op_word[op_cnt] = mem_word;
            end
            op_cnt++;
            if (!stall) begin
                mem_busy  <= 1'b1;
                busy_left <= busy_len;
            end
        end else if (mem_busy) begin
            if (busy_left <= 1) mem_busy <= 1'b0;
            else busy_left <= busy_left - 1;
        end
    end

    int errors = 0, checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, acks;
        logic got;
        logic [7:0] dq;

        // Reset values
        tick(); tick();
        check("rst_mem_rd", mem_rd, 0);
        check("rst_mem_wr", mem_wr, 0);
        check("rst_snes_q", snes_q, 0);
        check("rst_dump_q", dump_q, 0);
        check("rst_snes_busy", snes_busy, 0);
        check("rst_acks", {ld_ack, dump_ack}, 0);
        check("rst_mem_addr", mem_addr, 0);
        reset = 1'b0;
        tick();

        // Loader write
        base = op_cnt;
        ld_addr = 25'h0000123; ld_data = 16'hBEEF; ld_wr = 1'b1;
        tick();
        check("ld_issue_wr", {mem_wr, mem_rd}, 2'b10);
        check("ld_issue_addr", mem_addr, 32'h123);
        check("ld_issue_word", mem_word, 1);
        check("ld_issue_din", mem_din, 16'hBEEF);
        tick();
        check("ld_wr_pulse", mem_wr, 0);
        tick(); tick();
        check("ld_busy_fell", mem_busy, 0);
        check("ld_ack_early", ld_ack, 0);
        check("ld_addr_hold", mem_addr, 32'h123);
        tick();
        check("ld_ack", ld_ack, 1);
        ld_wr = 1'b0;
        tick();
        check("ld_ack_once", ld_ack, 0);
        check("ld_op_count", op_cnt - base, 1);

        // SNES BSRAM write
        model_dout = 16'hDEAD;
        base = op_cnt;
        snes_bs_addr = 20'h00010; snes_bs_d = 8'h5A; snes_bs_wr = 1'b1;
        tick();
        check("bsw_issue_wr", {mem_wr, mem_rd}, 2'b10);
        check("bsw_addr", mem_addr, 32'h1000010);
        check("bsw_din", mem_din, 16'h5A5A);
        check("bsw_word", mem_word, 0);
        check("bsw_busy", snes_busy, 1);
        for (int i = 0; i < 20 && snes_busy; i++) tick();
        check("bsw_done", snes_busy, 0);
        check("bsw_snes_q", snes_q, 0);
        check("bsw_op_count", op_cnt - base, 1);
        snes_bs_wr = 1'b0;
        tick();

        // SNES ROM read, then address change while read held
        model_dout = 16'h1234;
        snes_rom_word = 1'b1; snes_rom_addr = 24'h008000; snes_rom_rd = 1'b1;
        tick();
        check("rom_issue_rd", {mem_wr, mem_rd}, 2'b01);
        check("rom_addr", mem_addr, 32'h0008000);
        check("rom_word", mem_word, 1);
        tick(); tick(); tick(); tick();
        check("rom_q", snes_q, 16'h1234);
        check("rom_busy_done", snes_busy, 1);
        tick();
        check("rom_idle", snes_busy, 0);
        base = op_cnt;
        model_dout = 16'h5678;
        snes_rom_addr = 24'h008002;
        tick();
        check("rom2_issue_rd", mem_rd, 1);
        check("rom2_addr", mem_addr, 32'h0008002);
        tick(); tick(); tick(); tick();
        check("rom2_q", snes_q, 16'h5678);
        snes_rom_rd = 1'b0;
        tick(); tick(); tick();
        check("rom_no_extra", op_cnt - base, 1);

        // Three requesters in the same cycle
        base = op_cnt;
        model_dout = 16'h77C3;
        ld_addr = 25'h00ABCDE; ld_data = 16'h1111; ld_wr = 1'b1;
        dump_addr = 20'h00042; dump_rd = 1'b1;
        snes_rom_word = 1'b0; snes_rom_addr = 24'h00A000; snes_rom_rd = 1'b1;
        got = 1'b0; dq = '0;
        for (int i = 0; i < 60 && !got; i++) begin
            tick();
            if (ld_ack) ld_wr = 1'b0;
            if (dump_ack) begin
                got = 1'b1;
                dq = dump_q;
                dump_rd = 1'b0;
            end
        end
        check("arb_dump_ack", got, 1);
        check("arb_dump_q", dq, 8'hC3);
        check("arb_op_count", op_cnt - base, 3);
        check("arb_op0", {op_rd[base], op_word[base], 7'h0, op_addr[base]}, {1'b1, 1'b0, 7'h0, 25'h000A000});
        check("arb_op1", {op_rd[base+1], op_word[base+1], 7'h0, op_addr[base+1]}, {1'b0, 1'b1, 7'h0, 25'h0ABCDE});
        check("arb_op1_din", op_din[base+1], 16'h1111);
        check("arb_op2", {op_rd[base+2], op_word[base+2], 7'h0, op_addr[base+2]}, {1'b1, 1'b0, 7'h0, 25'h1000042});
        check("arb_snes_q", snes_q, 16'h77C3);
        check("arb_overlap", overlap, 0);
        snes_rom_rd = 1'b0;
        tick(); tick();

        // Controller never raises busy: forced completion
        stall = 1'b1;
        model_dout = 16'hAA55;
        dump_addr = 20'h00005; dump_rd = 1'b1;
        tick();
        check("to_issue_rd", mem_rd, 1);
        check("to_addr", mem_addr, 32'h1000005);
        for (int i = 0; i < 7; i++) tick();
        check("to_ack_early", dump_ack, 0);
        tick();
        check("to_ack", dump_ack, 1);
        check("to_dump_q", dump_q, 8'h55);
        dump_rd = 1'b0;
        tick();
        check("to_ack_once", dump_ack, 0);
        stall = 1'b0;
        tick();

        // Reset while waiting for the controller to finish
        busy_len = 6;
        ld_addr = 25'h0000055; ld_data = 16'h0F0F; ld_wr = 1'b1;
        tick();
        check("rm_issue", mem_wr, 1);
        tick(); tick();
        check("rm_busy_high", mem_busy, 1);
        base = op_cnt;
        acks = ld_ack_cnt;
        reset = 1'b1;
        ld_wr = 1'b0;
        #1;
        check("rm_mem_rdwr", {mem_rd, mem_wr}, 0);
        check("rm_mem_addr", mem_addr, 0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("rm_busy_fell", mem_busy, 0);
        check("rm_no_ack", ld_ack_cnt - acks, 0);
        check("rm_no_op", op_cnt - base, 0);
        check("rm_snes_busy", snes_busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
